alu_issue_arbiter: RTL and testbench
====================================

# alu_issue_arbiter

Two-port issue controller in front of the arithmetic/logic ALU. Requesters (decode/issue lanes 0 and 1) present operand pairs and an opselect/operation code over valid/ready. The block round-robin arbitrates between them, drives the ALU one op per cycle, and tracks in-flight ops through the ALU's registered result stage. Each result goes to a per-requester response FIFO, with credit-based backpressure so no result is ever dropped.

## Interface
Parameters:
- N, 32, operand width; ALU result is N+1 bits, signed
- RSP_DEPTH, 4, entries per response FIFO (power of two, ≥2)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted when valid&ready
- req_in1  in  2*N  operand 1, lane i at [i*N +: N]
- req_in2  in  2*N  operand 2
- req_op  in  2*3  operation code, lane i at [i*3 +: 3]
- req_sel  in  2*3  opselect code
- rsp_valid  out  2  response FIFO non-empty
- rsp_ready  in  2  response popped when valid&ready
- rsp_data  out  2*(N+1)  head result, lane i at [i*(N+1) +: N+1]
- rsp_err  out  2  head entry was an illegal opselect
- alu_in1, alu_in2  out  N  ALU operands
- alu_operation, alu_opselect  out  3  ALU codes
- alu_enable  out  1  ALU enable
- alu_out  in  N+1  ALU registered result

## Operation
- Legal opselect values: 3'b001 (arith/logic), 3'b101 (mem-read extend). Any other value is accepted, never sent to the ALU (alu_enable stays 0 in that slot), and returns rsp_err=1 with rsp_data=0.
- Credit per lane: credit_i = FIFO occupancy + in-flight ops for lane i. Lane i is eligible when req_valid[i] and credit_i < RSP_DEPTH.
- Arbitration: at most one grant per cycle. req_ready is combinational from eligibility and the round-robin pointer `rr`. If both lanes are eligible, lane rr wins. rr updates to the loser only on a contested grant. An uncontested grant leaves rr unchanged.
- Issue stage S1 (registered at the grant edge):
  - alu_* operands and codes
  - alu_enable = granted & legal
  - tag {v, lane, err}
- Stage S2: tag shifts forward. The ALU has registered the result, so alu_out is valid during S2.
- Write-back at the end of S2: if tag.v, push {err ? 0 : alu_out, err} into FIFO[lane]. alu_out is sampled only for legal tags, because the ALU holds stale data otherwise.
- FIFO: RSP_DEPTH entries, first-word fall-through head. Push and pop in the same cycle are allowed, including when the FIFO is full; credits guarantee a push never overflows.
- Idle slots: alu_enable=0 and alu_in*/codes hold their last values.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0
  - alu_enable=0, alu_in1=alu_in2=0, alu_operation=alu_opselect=0
  - rr=0, all tags invalid, FIFOs empty, credits 0
- Latency: handshake in cycle t gives alu_enable=1 in t+1, alu_out valid in t+2, rsp_valid=1 in t+3 (if the FIFO was empty).
- Throughput: one issue per cycle across both lanes. A single lane with rsp_ready held high sustains one op/cycle when RSP_DEPTH ≥ 3.
- Credit decrements on the pop cycle, so a lane becomes eligible in the same cycle as a pop of its full FIFO.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded. Nothing from before reset appears on rsp_*.
- Back-to-back ops from different lanes write back to different FIFOs in consecutive cycles; ordering within a lane is strictly preserved.

## Test plan
- Single op: lane0 sel=001 op=ADD, in1=5, in2=7 → alu_enable pulses 1 cycle later; rsp_valid[0]=1 three cycles after handshake, rsp_data0=12, rsp_err[0]=0.
- Sign width: lane1 SUB, in1=3, in2=5 → rsp_data1=33'h1_FFFF_FFFE. Lane1 sel=101 op=000, in2=32'h80 → 33'h0_FFFF_FF80.
- Contention: both lanes valid continuously with rsp_ready=2'b11 → grants alternate 0,1,0,1 starting with lane0, one alu_enable per cycle, each lane's results returned in order.
- Backpressure: rsp_ready[0]=0, lane0 streams → exactly 4 accepts, then req_ready[0]=0 while lane1 continues to be served. Raise rsp_ready[0] → lane0 is re-granted in the same cycle as the first pop.
- Illegal opselect: lane0 sel=000 → alu_enable stays 0 for that slot; response has rsp_err=1, rsp_data=0, same 3-cycle latency.
- Reset mid-flight: issue 3 ops, assert reset for 1 cycle at t+1 → all outputs return to reset values, no stale responses appear, and the next op completes normally.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// Two-lane round-robin issue controller in front of a registered-output ALU.
// Tracks in-flight ops and returns each result through a per-lane response FIFO.
module alu_issue_arbiter #(
  parameter int N         = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*N-1:0]     req_in1,
  input  logic [2*N-1:0]     req_in2,
  input  logic [5:0]         req_op,
  input  logic [5:0]         req_sel,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [2*(N+1)-1:0] rsp_data,
  output logic [1:0]         rsp_err,
  output logic [N-1:0]       alu_in1,
  output logic [N-1:0]       alu_in2,
  output logic [2:0]         alu_operation,
  output logic [2:0]         alu_opselect,
  output logic               alu_enable,
  input  logic [N:0]         alu_out
);

  localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = AW + 2;
  localparam logic [2:0] SEL_ARITH = 3'b001;
  localparam logic [2:0] SEL_MEMRD = 3'b101;

  logic          rr;
  logic          s1_v, s1_lane, s1_err;
  logic          s2_v, s2_lane, s2_err;
  logic [AW:0]   count  [2];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [N:0]    fifo_data [2][RSP_DEPTH];
  logic          fifo_err  [2][RSP_DEPTH];
  logic [1:0]    push, pop, elig, grant;
  logic [CW-1:0] credit [2];
  logic          g_any, g_lane, g_legal;
  logic [2:0]    g_sel;

  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both high; valid never waits on ready, ready may depend on valid.
  // A lane's credit counts FIFO entries plus ops in S1/S2, minus a pop this
  // cycle, so a full FIFO being popped frees its lane in the same cycle.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = '0;
    pop       = '0;
    push      = '0;
    elig      = '0;
    for (int i = 0; i < 2; i++) begin
      credit[i]    = '0;
      rsp_valid[i] = !reset && (count[i] != '0);
      pop[i]       = rsp_valid[i] && rsp_ready[i];
      push[i]      = s2_v && (s2_lane == 1'(i));
      credit[i]    = CW'(count[i]) + CW'(s1_v && (s1_lane == 1'(i)))
                   + CW'(push[i]) - CW'(pop[i]);
      elig[i]      = !reset && req_valid[i] && (credit[i] < CW'(RSP_DEPTH));
      rsp_data[i*(N+1) +: N+1] = rsp_valid[i] ? fifo_data[i][rd_ptr[i]] : '0;
      rsp_err[i]   = rsp_valid[i] && fifo_err[i][rd_ptr[i]];
    end
    req_ready[0] = elig[0] && (!elig[1] || !rr);
    req_ready[1] = elig[1] && (!elig[0] || rr);
    grant   = req_ready;
    g_any   = |grant;
    g_lane  = grant[1];
    g_sel   = g_lane ? req_sel[5:3] : req_sel[2:0];
    g_legal = (g_sel == SEL_ARITH) || (g_sel == SEL_MEMRD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr            <= 1'b0;
      s1_v          <= 1'b0;
      s1_lane       <= 1'b0;
      s1_err        <= 1'b0;
      s2_v          <= 1'b0;
      s2_lane       <= 1'b0;
      s2_err        <= 1'b0;
      alu_enable    <= 1'b0;
      alu_in1       <= '0;
      alu_in2       <= '0;
      alu_operation <= '0;
      alu_opselect  <= '0;
      for (int i = 0; i < 2; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      alu_enable <= g_any && g_legal;
      // Illegal opselects never reach the ALU pins; they keep their last values.
      if (g_any && g_legal) begin
        alu_in1       <= g_lane ? req_in1[2*N-1:N] : req_in1[N-1:0];
        alu_in2       <= g_lane ? req_in2[2*N-1:N] : req_in2[N-1:0];
        alu_operation <= g_lane ? req_op[5:3] : req_op[2:0];
        alu_opselect  <= g_sel;
      end
      s1_v    <= g_any;
      s1_lane <= g_lane;
      s1_err  <= !g_legal;
      s2_v    <= s1_v;
      s2_lane <= s1_lane;
      s2_err  <= s1_err;
      if (&elig) rr <= !g_lane;
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
    end
  end

  // alu_out is only meaningful for legal tags; error slots store zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        fifo_data[i][wr_ptr[i]] <= s2_err ? '0 : alu_out;
        fifo_err[i][wr_ptr[i]]  <= s2_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: per-lane request driver, a small ALU
// model behind the issue port, and a response scoreboard fed at handshake time.
`timescale 1ns/1ps
module tb_alu_issue_arbiter;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] SEL_AR = 3'b001;
  localparam logic [2:0] SEL_MR = 3'b101;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  op;
    logic [2:0]  sel;
    logic [33:0] exp;
  } vec_t;

  logic        clock, reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_in1, req_in2;
  logic [5:0]  req_op, req_sel;
  logic [65:0] rsp_data;
  logic [31:0] alu_in1, alu_in2;
  logic [2:0]  alu_operation, alu_opselect;
  logic        alu_enable;
  logic [32:0] alu_out;

  vec_t        pend0[$], pend1[$];
  logic [33:0] exp_q0[$], exp_q1[$];
  logic        grant_log[$];
  int          grant_cyc[$];
  int          hs_count[2];
  int          cyc, checks, errors;

  alu_issue_arbiter #(.N(32), .RSP_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_operation(alu_operation),
    .alu_opselect(alu_opselect), .alu_enable(alu_enable), .alu_out(alu_out)
  );

  // clock/reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ALU model with a registered result, holding stale data when not enabled
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic [2:0] sel);
    logic [32:0] r;
    r = '0;
    if (sel == SEL_AR) begin
      case (op)
        OP_ADD:  r = {a[31], a} + {b[31], b};
        OP_SUB:  r = {a[31], a} - {b[31], b};
        default: r = {1'b0, a & b};
      endcase
    end else if (sel == SEL_MR) begin
      r = {1'b0, {24{b[7]}}, b[7:0]};
    end
    return r;
  endfunction

  initial alu_out = '0;
  always @(posedge clock)
    if (alu_enable) alu_out <= alu_model(alu_in1, alu_in2, alu_operation, alu_opselect);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic add_vec(input int lane, input logic [31:0] in1, input logic [31:0] in2,
                         input logic [2:0] op, input logic [2:0] sel,
                         input logic err, input logic [32:0] data);
    vec_t v;
    v.in1 = in1; v.in2 = in2; v.op = op; v.sel = sel; v.exp = {err, data};
    if (lane == 0) pend0.push_back(v);
    else           pend1.push_back(v);
  endtask

  // driver: presents each lane's head, moves it to the scoreboard on handshake
  initial begin
    vec_t v;
    logic [1:0] hs;
    req_valid = '0; req_in1 = '0; req_in2 = '0; req_op = '0; req_sel = '0;
    hs_count[0] = 0; hs_count[1] = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hs = req_valid & req_ready;
        if (hs[0]) begin v = pend0.pop_front(); exp_q0.push_back(v.exp); hs_count[0]++; end
        if (hs[1]) begin v = pend1.pop_front(); exp_q1.push_back(v.exp); hs_count[1]++; end
        if (hs != 2'b00) begin
          check("one_grant_per_cycle", 64'(hs == 2'b11), 64'd0);
          grant_log.push_back(hs[1]);
          grant_cyc.push_back(cyc);
        end
      end
      @(posedge clock);
      #1;
      req_valid[0] = (pend0.size() != 0);
      if (req_valid[0]) begin
        v = pend0[0];
        req_in1[31:0] = v.in1; req_in2[31:0] = v.in2; req_op[2:0] = v.op; req_sel[2:0] = v.sel;
      end
      req_valid[1] = (pend1.size() != 0);
      if (req_valid[1]) begin
        v = pend1[0];
        req_in1[63:32] = v.in1; req_in2[63:32] = v.in2; req_op[5:3] = v.op; req_sel[5:3] = v.sel;
      end
    end
  end

  // scoreboard monitor: compares every popped response with its lane's queue
  initial begin
    logic [33:0] got, exp;
    forever begin
      @(negedge clock);
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            got = {rsp_err[i], rsp_data[i*33 +: 33]};
            if (i == 0 && exp_q0.size() != 0) begin
              exp = exp_q0.pop_front();
              check("rsp_lane0", 64'(got), 64'(exp));
            end else if (i == 1 && exp_q1.size() != 0) begin
              exp = exp_q1.pop_front();
              check("rsp_lane1", 64'(got), 64'(exp));
            end else begin
              checks++;
              errors++;
              $display("FAIL unexpected_rsp lane%0d: got %h, expected none", i, got);
            end
          end
        end
      end
    end
  end

  task automatic wait_hs(input int lane);
    int base, k;
    base = hs_count[lane];
    k = 0;
    while (hs_count[lane] == base && k < 50) begin
      step();
      k++;
    end
    check("handshake_seen", 64'(hs_count[lane] != base), 64'd1);
  endtask

  task automatic lat_check(input int lane, input logic exp_en);
    wait_hs(lane);
    check("alu_enable_t1", 64'(alu_enable), 64'(exp_en));
    step();
    check("rsp_valid_t2", 64'(rsp_valid[lane]), 64'd0);
    step();
    check("rsp_valid_t3", 64'(rsp_valid[lane]), 64'd1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((pend0.size() + pend1.size() + exp_q0.size() + exp_q1.size()) != 0 && k < 200) begin
      step();
      k++;
    end
    check("drain", 64'(pend0.size() + pend1.size() + exp_q0.size() + exp_q1.size()), 64'd0);
  endtask

  initial begin
    int b0, b1;
    checks = 0; errors = 0;
    reset = 1'b1; rsp_ready = 2'b00;
    repeat (3) step();

    // reset values, with a request already pending on lane 0
    add_vec(0, 32'd5, 32'd7, OP_ADD, SEL_AR, 1'b0, 33'd12);
    step();
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_alu_enable", 64'(alu_enable), 64'd0);
    check("reset_alu_in1", 64'(alu_in1), 64'd0);
    check("reset_alu_in2", 64'(alu_in2), 64'd0);
    check("reset_alu_codes", 64'({alu_operation, alu_opselect}), 64'd0);

    // single op and sign/width handling
    rsp_ready = 2'b11;
    reset = 1'b0;
    lat_check(0, 1'b1);
    check("alu_in1_hold", 64'(alu_in1), 64'd5);
    check("alu_in2_hold", 64'(alu_in2), 64'd7);
    add_vec(1, 32'd3, 32'd5, OP_SUB, SEL_AR, 1'b0, 33'h1_FFFF_FFFE);
    lat_check(1, 1'b1);
    add_vec(1, 32'h1234, 32'h80, 3'b000, SEL_MR, 1'b0, 33'h0_FFFF_FF80);
    lat_check(1, 1'b1);
    check("alu_opselect_memrd", 64'(alu_opselect), 64'(SEL_MR));

    // illegal opselect: no ALU slot, zero data with error flag
    add_vec(0, 32'd9, 32'd9, OP_ADD, 3'b000, 1'b1, 33'd0);
    lat_check(0, 1'b0);
    check("alu_in1_held_illegal", 64'(alu_in1), 64'h1234);
    wait_drain();

    // contention: alternate grants starting with lane 0
    grant_log.delete();
    grant_cyc.delete();
    add_vec(0, 32'd1, 32'd2, OP_ADD, SEL_AR, 1'b0, 33'd3);
    add_vec(0, 32'd10, 32'd20, OP_ADD, SEL_AR, 1'b0, 33'd30);
    add_vec(0, 32'hFFFF_FFFF, 32'd1, OP_ADD, SEL_AR, 1'b0, 33'd0);
    add_vec(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, OP_ADD, SEL_AR, 1'b0, 33'h0_FFFF_FFFE);
    add_vec(1, 32'd9, 32'd4, OP_SUB, SEL_AR, 1'b0, 33'd5);
    add_vec(1, 32'd4, 32'd9, OP_SUB, SEL_AR, 1'b0, 33'h1_FFFF_FFFB);
    add_vec(1, 32'h8000_0000, 32'd1, OP_SUB, SEL_AR, 1'b0, 33'h1_7FFF_FFFF);
    add_vec(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, OP_SUB, SEL_AR, 1'b0, 33'h0_8000_0000);
    wait_drain();
    check("contention_grants", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < grant_log.size(); i++)
      check("contention_order", 64'(grant_log[i]), 64'(i % 2));
    if (grant_cyc.size() == 8)
      check("contention_back_to_back", 64'(grant_cyc[7] - grant_cyc[0]), 64'd7);

    // backpressure on lane 0 while lane 1 keeps flowing
    rsp_ready = 2'b10;
    b0 = hs_count[0];
    b1 = hs_count[1];
    for (int i = 0; i < 6; i++)
      add_vec(0, 32'(100 + i), 32'd1, OP_ADD, SEL_AR, 1'b0, 33'(101 + i));
    for (int i = 0; i < 3; i++)
      add_vec(1, 32'(50 + i), 32'd10, OP_SUB, SEL_AR, 1'b0, 33'(40 + i));
    repeat (15) step();
    check("bp_lane0_accepts", 64'(hs_count[0] - b0), 64'd4);
    check("bp_lane1_accepts", 64'(hs_count[1] - b1), 64'd3);
    check("bp_lane0_blocked", 64'(req_ready[0]), 64'd0);
    check("bp_lane0_full_valid", 64'(rsp_valid[0]), 64'd1);
    rsp_ready = 2'b11;
    #1;
    check("bp_regrant_on_pop", 64'(req_ready[0]), 64'd1);
    wait_drain();

    // reset one cycle after a handshake discards everything in flight
    add_vec(0, 32'd1, 32'd1, OP_ADD, SEL_AR, 1'b0, 33'd2);
    add_vec(0, 32'd2, 32'd2, OP_ADD, SEL_AR, 1'b0, 33'd4);
    add_vec(0, 32'd3, 32'd3, OP_ADD, SEL_AR, 1'b0, 33'd6);
    wait_hs(0);
    reset = 1'b1;
    pend0.delete();
    exp_q0.delete();
    step();
    reset = 1'b0;
    check("midreset_alu_enable", 64'(alu_enable), 64'd0);
    check("midreset_alu_in1", 64'(alu_in1), 64'd0);
    check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midreset_req_ready", 64'(req_ready), 64'd0);
    repeat (5) begin
      step();
      check("midreset_no_stale", 64'({rsp_valid, rsp_err}), 64'd0);
    end
    add_vec(0, 32'd20, 32'd22, OP_ADD, SEL_AR, 1'b0, 33'd42);
    lat_check(0, 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
